exec_trace_buffer: RTL and testbench
====================================

Name: exec_trace_buffer

Overview:
- Hardware retirement tracer that sits directly downstream of the core datapath.
- Captures one record per retired instruction: PC, instruction word, register-file write, data-memory write.
- Records go into a circular FIFO that a host or debug port drains with a valid/ready handshake.
- Detects the HALT opcode (instr[15:12] == 4'hF), logs it as the final record, then freezes capture.

Parameters:
- DEPTH, 16, number of trace records; power of two, >= 4.
- DROP_W, 8, width of the saturating dropped-record counter.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- arm_i  input  1  one-cycle pulse; starts capture.
- clear_i  input  1  one-cycle pulse; empties FIFO, zeroes counters, returns to IDLE.
- valid_i  input  1  one instruction retires this cycle.
- pc_i  input  8  PC of the retiring instruction.
- instr_i  input  16  retiring instruction word.
- reg_we_i  input  1  register-file write enable.
- reg_addr_i  input  3  destination register R0..R7.
- reg_wdata_i  input  8  register write data.
- mem_we_i  input  1  data-memory write enable.
- mem_addr_i  input  8  data-memory address.
- mem_wdata_i  input  8  data-memory write data.
- rd_ready_i  input  1  consumer accepts the head record.
- rd_valid_o  output  1  head record available.
- rd_data_o  output  48  head record; layout below.
- count_o  output  log2(DEPTH)+1  current occupancy.
- drop_cnt_o  output  DROP_W  records lost because the FIFO was full; saturating.
- overflow_o  output  1  sticky; set on the first dropped record.
- capturing_o  output  1  high in CAPTURE.
- halted_o  output  1  high in FROZEN.

Behaviour:
- Record layout:
  - [47:40] pc
  - [39:24] instr
  - [23] reg_we
  - [22:20] reg_addr
  - [19:12] data: reg_wdata_i if reg_we_i, else mem_wdata_i if mem_we_i, else 0
  - [11] mem_we
  - [10:3] mem_addr, or 0 if !mem_we_i
  - [2:0] 3'b000
- If reg_we_i and mem_we_i are both set, data carries reg_wdata_i and both flags are recorded.
- Reset (reset == 0, asynchronous):
  - State = IDLE; read/write pointers and count = 0.
  - drop_cnt_o = 0; overflow_o = 0.
  - rd_valid_o = 0; rd_data_o = 0.
  - capturing_o = 0; halted_o = 0.
  - FIFO storage contents are don't-care.
- State machine, states IDLE, CAPTURE, FROZEN:
  - IDLE: valid_i is ignored. arm_i moves to CAPTURE; the FIFO is not cleared.
  - CAPTURE: each valid_i cycle enqueues one record. If that record has instr[15:12] == 4'hF, move to FROZEN on the same edge.
  - FROZEN: valid_i is ignored; arm_i is ignored.
  - clear_i in any state: return to IDLE, empty the FIFO, zero drop_cnt_o and overflow_o.
  - clear_i has priority over arm_i, enqueue and dequeue in the same cycle.
- FIFO:
  - First-word-fall-through. rd_valid_o = (count != 0); rd_data_o shows the head entry.
  - A record enqueued at edge N is visible on rd_data_o after edge N; it is readable in cycle N+1 if the FIFO was empty.
  - Dequeue happens on (rd_valid_o && rd_ready_i). The read pointer advances modulo DEPTH.
  - Reads are allowed in every state, including IDLE and FROZEN.
- Full boundary:
  - When count == DEPTH, an enqueue is accepted only if a dequeue occurs in the same cycle; count then stays at DEPTH.
  - Otherwise the record is dropped: drop_cnt_o increments (saturating at all-ones) and overflow_o sets.
  - A dropped HALT record still causes the transition to FROZEN.
- Empty boundary: simultaneous enqueue and rd_ready_i while empty is an enqueue only; rd_valid_o was 0, so no dequeue.
- Pointer wrap: pointers wrap modulo DEPTH; full and empty are distinguished by count.
- Reset asserted mid-capture or mid-drain: all state is lost immediately and no partial record survives.

Test Plan:
- Reset then arm; retire PC=00 instr=7240 (LOAD R1, reg_we=1, reg_addr=1, wdata=3C) -> next cycle rd_valid_o=1, rd_data_o=0x00_7240_9_3C_0_00 packed per layout, count_o=1.
- Retire 3 instructions with rd_ready_i=0, then hold rd_ready_i=1 -> records leave in order, one per cycle; rd_valid_o drops after the third; count_o goes 3,2,1,0.
- DEPTH=16: retire 20 instructions with no reads -> count_o=16, drop_cnt_o=4, overflow_o=1; retire a 17th while rd_ready_i=1 -> accepted, drop_cnt_o unchanged, count_o stays 16.
- Retire instr=F000 at PC=0A -> it is the last record, halted_o=1 and capturing_o=0 next cycle; further valid_i is ignored; FIFO drains normally.
- FIFO with 5 records; pulse clear_i and arm_i in the same cycle -> state IDLE, count_o=0, drop_cnt_o=0, overflow_o=0, rd_valid_o=0.
- Pull reset low asynchronously between clock edges while in CAPTURE with 7 records -> all outputs reach reset values before the next edge; after release, valid_i is ignored until arm_i.

Source files
------------

// File: rtl/exec_trace_buffer.sv
// Retirement trace buffer: packs one record per retired instruction into a
// first-word-fall-through circular FIFO that a host drains with valid/ready.
// A HALT opcode (instr[15:12] == 4'hF) is logged as the final record and
// then freezes capture until clear_i.
module exec_trace_buffer #(
  parameter  int DEPTH  = 16,
  parameter  int DROP_W = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm_i,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [7:0]        pc_i,
  input  logic [15:0]       instr_i,
  input  logic              reg_we_i,
  input  logic [2:0]        reg_addr_i,
  input  logic [7:0]        reg_wdata_i,
  input  logic              mem_we_i,
  input  logic [7:0]        mem_addr_i,
  input  logic [7:0]        mem_wdata_i,
  input  logic              rd_ready_i,
  output logic              rd_valid_o,
  output logic [47:0]       rd_data_o,
  output logic [CW-1:0]     count_o,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic              overflow_o,
  output logic              capturing_o,
  output logic              halted_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FROZEN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic                overflow_q, overflow_d;

  logic [47:0]         storage [DEPTH];
  logic [47:0]         record;
  logic [7:0]          record_data;
  logic                is_halt;
  logic                enq_req;
  logic                deq;
  logic                full;
  logic                enq_ok;
  logic                drop;

  // Pack the retiring instruction; register data wins over store data
  always_comb begin
    record_data = 8'h00;
    if (reg_we_i) begin
      record_data = reg_wdata_i;
    end else if (mem_we_i) begin
      record_data = mem_wdata_i;
    end
    record = {pc_i,
              instr_i,
              reg_we_i,
              reg_addr_i,
              record_data,
              mem_we_i,
              (mem_we_i ? mem_addr_i : 8'h00),
              3'b000};
  end

  // Qualify enqueue and dequeue; clear_i overrides every other action
  always_comb begin
    is_halt = (instr_i[15:12] == 4'hF);
    enq_req = (state_q == ST_CAPTURE) && valid_i && !clear_i;
    deq     = (count_q != '0) && rd_ready_i && !clear_i;
    full    = (count_q == CW'(DEPTH));
    enq_ok  = enq_req && (!full || deq);
    drop    = enq_req && full && !deq;
  end

  // Capture state machine; a HALT ends capture even if its record is dropped
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_i) begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (valid_i && is_halt) begin
            state_d = ST_FROZEN;
          end
        end
        ST_FROZEN: begin
          state_d = ST_FROZEN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Circular pointers wrap naturally; occupancy tells full from empty
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(enq_ok) - CW'(deq);
    end
  end

  // Saturating drop counter and sticky overflow flag
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {DROP_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
  end

  // Control registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Record storage needs no reset; occupancy masks stale entries
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      storage[wr_ptr_q] <= record;
    end
  end

  // Present the head record, forced to zero whenever the FIFO is empty
  always_comb begin
    rd_valid_o  = (count_q != '0);
    rd_data_o   = rd_valid_o ? storage[rd_ptr_q] : 48'h0;
    count_o     = count_q;
    drop_cnt_o  = drop_cnt_q;
    overflow_o  = overflow_q;
    capturing_o = (state_q == ST_CAPTURE);
    halted_o    = (state_q == ST_FROZEN);
  end

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Self-checking bench for exec_trace_buffer: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_exec_trace_buffer;

  localparam int DEPTH  = 16;
  localparam int DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm_i, clear_i, valid_i;
  logic [7:0]  pc_i;
  logic [15:0] instr_i;
  logic        reg_we_i;
  logic [2:0]  reg_addr_i;
  logic [7:0]  reg_wdata_i;
  logic        mem_we_i;
  logic [7:0]  mem_addr_i, mem_wdata_i;
  logic        rd_ready_i;
  logic        rd_valid_o;
  logic [47:0] rd_data_o;
  logic [4:0]  count_o;
  logic [7:0]  drop_cnt_o;
  logic        overflow_o, capturing_o, halted_o;

  int checks = 0;
  int failures = 0;

  // Reference model: the trace as a queue plus a mode (0 idle, 1 capture, 2 frozen)
  logic [47:0] mq[$];
  int          m_mode = 0;
  int          m_drop = 0;
  bit          m_ovf = 0;

  exec_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset(reset), .arm_i(arm_i), .clear_i(clear_i),
    .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
    .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .count_o(count_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o),
    .capturing_o(capturing_o), .halted_o(halted_o)
  );

  // Free-running core clock
  always #5 clk = ~clk;

  // Build a trace record straight from the field layout
  function automatic logic [47:0] make_rec(input logic [7:0] pc, input logic [15:0] ins,
                                           input logic rwe, input logic [2:0] ra,
                                           input logic [7:0] rwd, input logic mwe,
                                           input logic [7:0] ma, input logic [7:0] mwd);
    logic [7:0] d;
    d = rwe ? rwd : (mwe ? mwd : 8'h00);
    return {pc, ins, rwe, ra, d, mwe, (mwe ? ma : 8'h00), 3'b000};
  endfunction

  function automatic logic [47:0] cur_rec();
    return make_rec(pc_i, instr_i, reg_we_i, reg_addr_i, reg_wdata_i,
                    mem_we_i, mem_addr_i, mem_wdata_i);
  endfunction

  function automatic logic [47:0] exp_head();
    return (mq.size() != 0) ? mq[0] : 48'h0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mode = 0;
    m_drop = 0;
    m_ovf  = 0;
  endtask

  task automatic idle_inputs();
    arm_i = 0; clear_i = 0; valid_i = 0; pc_i = 0; instr_i = 0;
    reg_we_i = 0; reg_addr_i = 0; reg_wdata_i = 0;
    mem_we_i = 0; mem_addr_i = 0; mem_wdata_i = 0; rd_ready_i = 0;
  endtask

  task automatic set_retire(input logic [7:0] pc, input logic [15:0] ins);
    valid_i = 1; pc_i = pc; instr_i = ins;
    reg_we_i = 1'($urandom); reg_addr_i = 3'($urandom); reg_wdata_i = 8'($urandom);
    mem_we_i = 1'($urandom); mem_addr_i = 8'($urandom); mem_wdata_i = 8'($urandom);
  endtask

  // Advance the model by the current inputs, then clock the DUT and settle
  task automatic tick();
    int          sz;
    bit          deq, enq;
    logic [47:0] rec;
    sz  = mq.size();
    deq = (sz > 0) && rd_ready_i;
    enq = (m_mode == 1) && valid_i;
    rec = cur_rec();
    if (clear_i) begin
      model_reset();
    end else begin
      if (deq) void'(mq.pop_front());
      if (enq) begin
        if (sz < DEPTH || deq) mq.push_back(rec);
        else begin
          if (m_drop < DROP_MAX) m_drop++;
          m_ovf = 1;
        end
        if (instr_i[15:12] == 4'hF) m_mode = 2;
      end else if (m_mode == 0 && arm_i) begin
        m_mode = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    model_reset();
    #12;
    checks++; if (rd_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid got=%0b exp=0", rd_valid_o); end
    checks++; if (rd_data_o !== 48'h0) begin failures++; $display("[TB] FAIL reset_rd_data got=%h exp=0", rd_data_o); end
    checks++; if (count_o !== 5'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if ({drop_cnt_o, overflow_o, capturing_o, halted_o} !== 11'h0) begin
      failures++; $display("[TB] FAIL reset_flags got drop=%0d ovf=%0b cap=%0b halt=%0b exp all 0",
                           drop_cnt_o, overflow_o, capturing_o, halted_o);
    end
    @(negedge clk);
    reset = 1;
    tick();
  endtask

  task automatic test_first_record();
    arm_i = 1; tick(); arm_i = 0;
    checks++; if (capturing_o !== 1'b1) begin failures++; $display("[TB] FAIL arm_capturing got=%0b exp=1", capturing_o); end
    valid_i = 1; pc_i = 8'h00; instr_i = 16'h7240; reg_we_i = 1; reg_addr_i = 3'd1;
    reg_wdata_i = 8'h3C; mem_we_i = 0; mem_addr_i = 8'h55; mem_wdata_i = 8'hAA;
    tick();
    idle_inputs();
    checks++; if (rd_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL first_rd_valid got=%0b exp=1", rd_valid_o); end
    checks++; if (rd_data_o !== 48'h0072_4093_C000) begin failures++; $display("[TB] FAIL first_rd_data got=%h exp=%h", rd_data_o, 48'h0072_4093_C000); end
    checks++; if (count_o !== 5'd1) begin failures++; $display("[TB] FAIL first_count got=%0d exp=1", count_o); end
    rd_ready_i = 1; tick(); rd_ready_i = 0;
    checks++; if (count_o !== 5'd0) begin failures++; $display("[TB] FAIL first_drain_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_drain_order();
    for (int i = 0; i < 3; i++) begin
      set_retire(8'(8'h10 + i), 16'($urandom_range(0, 16'hEFFF)));
      tick();
    end
    idle_inputs();
    rd_ready_i = 1;
    for (int i = 3; i >= 0; i--) begin
      checks++; if (count_o !== 5'(i)) begin failures++; $display("[TB] FAIL drain_count got=%0d exp=%0d", count_o, i); end
      checks++; if (rd_valid_o !== (i != 0) || rd_data_o !== exp_head()) begin
        failures++; $display("[TB] FAIL drain_head got v=%0b d=%h exp v=%0b d=%h", rd_valid_o, rd_data_o, i != 0, exp_head());
      end
      if (i != 0) tick();
    end
    rd_ready_i = 0;
  endtask

  task automatic test_full();
    clear_i = 1; tick(); clear_i = 0;
    arm_i = 1; tick(); arm_i = 0;
    for (int i = 0; i < 20; i++) begin
      set_retire(8'(i), 16'($urandom_range(0, 16'hEFFF)));
      tick();
    end
    checks++; if (count_o !== 5'd16) begin failures++; $display("[TB] FAIL full_count got=%0d exp=16", count_o); end
    checks++; if (drop_cnt_o !== 8'd4) begin failures++; $display("[TB] FAIL full_drop got=%0d exp=4", drop_cnt_o); end
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("[TB] FAIL full_overflow got=%0b exp=1", overflow_o); end
    set_retire(8'h77, 16'h1234); rd_ready_i = 1;
    tick();
    idle_inputs();
    checks++; if (count_o !== 5'd16 || drop_cnt_o !== 8'd4) begin
      failures++; $display("[TB] FAIL full_swap got count=%0d drop=%0d exp count=16 drop=4", count_o, drop_cnt_o);
    end
    checks++; if (rd_data_o !== exp_head()) begin failures++; $display("[TB] FAIL full_head got=%h exp=%h", rd_data_o, exp_head()); end
  endtask

  task automatic test_drop_saturate();
    for (int i = 0; i < 260; i++) begin
      set_retire(8'(i), 16'($urandom_range(0, 16'hEFFF)));
      tick();
    end
    idle_inputs();
    checks++; if (drop_cnt_o !== 8'hFF || m_drop != DROP_MAX) begin
      failures++; $display("[TB] FAIL drop_saturate got=%0d exp=%0d", drop_cnt_o, DROP_MAX);
    end
  endtask

  task automatic test_halt();
    logic [47:0] halt_rec;
    clear_i = 1; tick(); clear_i = 0;
    arm_i = 1; tick(); arm_i = 0;
    set_retire(8'h08, 16'h1111); tick();
    set_retire(8'h0A, 16'hF000); halt_rec = cur_rec(); tick();
    idle_inputs();
    checks++; if (halted_o !== 1'b1 || capturing_o !== 1'b0) begin
      failures++; $display("[TB] FAIL halt_flags got halt=%0b cap=%0b exp halt=1 cap=0", halted_o, capturing_o);
    end
    set_retire(8'h0C, 16'h2222); arm_i = 1; tick(); tick();
    idle_inputs();
    checks++; if (count_o !== 5'd2 || halted_o !== 1'b1) begin
      failures++; $display("[TB] FAIL halt_ignore got count=%0d halt=%0b exp count=2 halt=1", count_o, halted_o);
    end
    rd_ready_i = 1; tick(); rd_ready_i = 0;
    checks++; if (rd_data_o !== halt_rec) begin failures++; $display("[TB] FAIL halt_last got=%h exp=%h", rd_data_o, halt_rec); end
    rd_ready_i = 1; tick(); rd_ready_i = 0;
    checks++; if (rd_valid_o !== 1'b0 || count_o !== 5'd0) begin
      failures++; $display("[TB] FAIL halt_drained got v=%0b count=%0d exp v=0 count=0", rd_valid_o, count_o);
    end
  endtask

  task automatic test_clear_priority();
    clear_i = 1; tick(); clear_i = 0;
    arm_i = 1; tick(); arm_i = 0;
    for (int i = 0; i < 5; i++) begin set_retire(8'(i), 16'h3000); tick(); end
    clear_i = 1; arm_i = 1; set_retire(8'h40, 16'h4000); rd_ready_i = 1;
    tick();
    idle_inputs();
    checks++; if (count_o !== 5'd0 || rd_valid_o !== 1'b0 || capturing_o !== 1'b0 || halted_o !== 1'b0) begin
      failures++; $display("[TB] FAIL clear_arm got count=%0d v=%0b cap=%0b halt=%0b exp all 0",
                           count_o, rd_valid_o, capturing_o, halted_o);
    end
    checks++; if (drop_cnt_o !== 8'd0 || overflow_o !== 1'b0) begin
      failures++; $display("[TB] FAIL clear_counters got drop=%0d ovf=%0b exp 0", drop_cnt_o, overflow_o);
    end
  endtask

  task automatic test_async_reset();
    arm_i = 1; tick(); arm_i = 0;
    for (int i = 0; i < 7; i++) begin set_retire(8'(i), 16'h5000); tick(); end
    idle_inputs();
    checks++; if (count_o !== 5'd7) begin failures++; $display("[TB] FAIL areset_pre_count got=%0d exp=7", count_o); end
    #2 reset = 0;
    model_reset();
    #1;
    checks++; if (count_o !== 5'd0 || rd_valid_o !== 1'b0 || rd_data_o !== 48'h0 || capturing_o !== 1'b0) begin
      failures++; $display("[TB] FAIL areset_immediate got count=%0d v=%0b d=%h cap=%0b exp all 0",
                           count_o, rd_valid_o, rd_data_o, capturing_o);
    end
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 3; i++) begin set_retire(8'(i), 16'h6000); tick(); end
    idle_inputs();
    checks++; if (count_o !== 5'd0 || capturing_o !== 1'b0) begin
      failures++; $display("[TB] FAIL areset_ignore got count=%0d cap=%0b exp 0", count_o, capturing_o);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      if ($urandom_range(0, 9) < 6) set_retire(8'($urandom), ($urandom_range(0, 39) == 0) ? 16'hF0A5 : 16'($urandom_range(0, 16'hEFFF)));
      arm_i      = ($urandom_range(0, 9) == 0);
      clear_i    = ($urandom_range(0, 59) == 0);
      rd_ready_i = ($urandom_range(0, 2) == 0);
      tick();
      checks++; if (rd_valid_o !== (mq.size() != 0) || rd_data_o !== exp_head()) begin
        failures++; $display("[TB] FAIL rand_head cyc=%0d got v=%0b d=%h exp v=%0b d=%h",
                             n, rd_valid_o, rd_data_o, mq.size() != 0, exp_head());
      end
      checks++; if (count_o !== 5'(mq.size()) || drop_cnt_o !== 8'(m_drop) || overflow_o !== m_ovf) begin
        failures++; $display("[TB] FAIL rand_counts cyc=%0d got c=%0d d=%0d o=%0b exp c=%0d d=%0d o=%0b",
                             n, count_o, drop_cnt_o, overflow_o, mq.size(), m_drop, m_ovf);
      end
      checks++; if (capturing_o !== (m_mode == 1) || halted_o !== (m_mode == 2)) begin
        failures++; $display("[TB] FAIL rand_mode cyc=%0d got cap=%0b halt=%0b exp mode=%0d",
                             n, capturing_o, halted_o, m_mode);
      end
    end
    idle_inputs();
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_first_record();
    test_drain_order();
    test_full();
    test_drop_saturate();
    test_halt();
    test_clear_priority();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
